special_box_placer: RTL and testbench

SPECIAL_BOX_PLACER -- requirements
Module: special_box_placer

---
 rtl/special_box_placer_pkg.sv | 29 ++
 rtl/special_box_placer_lfsr16.sv | 22 ++
 rtl/special_box_placer.sv | 151 +++++++++++++++
 tb/tb_special_box_placer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/special_box_placer_pkg.sv
// Shared constants, FSM encoding and cell type for the special box placer.
package special_box_placer_pkg;

    localparam int          GRID_W       = 24;
    localparam int          GRID_H       = 24;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    localparam int          MAX_ATTEMPTS = 64;
    localparam int          CNT_W        = 7;

    typedef enum logic [2:0] {
        IDLE,
        GEN_P,
        CHK_P,
        GEN_M,
        CHK_M,
        DRAW,
        REL
    } state_e;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
    } cell_t;

    function automatic logic in_grid(input cell_t c);
        return (int'(c.x) < GRID_W) && (int'(c.y) < GRID_H);
    endfunction

endpackage

// File: rtl/special_box_placer_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
module lfsr16
    import special_box_placer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic fb;

    assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= {q[14:0], fb};
        end
    end

endmodule

// File: rtl/special_box_placer.sv
// Picks a random open +5 cell and a distinct open -5 cell, then
// hands both to the draw stage through a draw/done handshake.
module special_box_placer
    import special_box_placer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       place,
    input  logic [4:0] playerX,
    input  logic [4:0] playerY,
    input  logic       mazeWall,
    input  logic       drawDone,
    output logic [4:0] mazeAddrX,
    output logic [4:0] mazeAddrY,
    output logic [4:0] xPlus,
    output logic [4:0] yPlus,
    output logic [4:0] xMinus,
    output logic [4:0] yMinus,
    output logic       drawSpecial,
    output logic       busy,
    output logic       ready,
    output logic       fail
);

    state_e           state;
    logic [15:0]      lfsr;
    logic [CNT_W-1:0] attempts;
    cell_t            cand;
    cell_t            addr_q;
    cell_t            pend;
    cell_t            player;
    logic             gen;
    logic             reject;
    logic             last_try;
    logic             unused_lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    assign cand        = {lfsr[4:0], lfsr[12:8]};
    assign player      = {playerX, playerY};
    assign unused_lfsr = ^{lfsr[15:13], lfsr[7:5]};
    assign gen         = (state == GEN_P) || (state == GEN_M);
    assign last_try    = attempts == CNT_W'(MAX_ATTEMPTS - 1);

    // The ROM registers its address, so the raw candidate is presented
    // during GEN and the wall bit arrives in the following CHK cycle.
    assign mazeAddrX = gen ? cand.x : addr_q.x;
    assign mazeAddrY = gen ? cand.y : addr_q.y;

    always_comb begin
        reject = 1'b0;
        unique case (1'b1)
            gen:
                reject = !in_grid(cand);
            state == CHK_P:
                reject = mazeWall || (addr_q == player);
            state == CHK_M:
                reject = mazeWall || (addr_q == player)
                      || (addr_q == pend);
            default:
                reject = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            attempts    <= '0;
            addr_q      <= '0;
            pend        <= '0;
            xPlus       <= '0;
            yPlus       <= '0;
            xMinus      <= '0;
            yMinus      <= '0;
            drawSpecial <= 1'b0;
            busy        <= 1'b0;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            ready <= 1'b0;
            fail  <= 1'b0;
            if (reject) begin
                if (last_try) begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    fail     <= 1'b1;
                    attempts <= '0;
                end else begin
                    attempts <= attempts + CNT_W'(1);
                    if (state == CHK_P) begin
                        state <= GEN_P;
                    end else if (state == CHK_M) begin
                        state <= GEN_M;
                    end
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (place) begin
                            state    <= GEN_P;
                            attempts <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    GEN_P: begin
                        addr_q <= cand;
                        state  <= CHK_P;
                    end
                    GEN_M: begin
                        addr_q <= cand;
                        state  <= CHK_M;
                    end
                    CHK_P: begin
                        pend     <= addr_q;
                        attempts <= '0;
                        state    <= GEN_M;
                    end
                    CHK_M: begin
                        xPlus       <= pend.x;
                        yPlus       <= pend.y;
                        xMinus      <= addr_q.x;
                        yMinus      <= addr_q.y;
                        drawSpecial <= 1'b1;
                        state       <= DRAW;
                    end
                    DRAW: begin
                        if (drawDone) begin
                            drawSpecial <= 1'b0;
                            ready       <= 1'b1;
                            state       <= REL;
                        end
                    end
                    REL: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        drawSpecial <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_special_box_placer.sv
// Scenario table plus reset sequences, checked against a placement model.
module tb_special_box_placer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       place = 1'b0;
    logic [4:0] playerX = '0;
    logic [4:0] playerY = '0;
    logic       mazeWall = 1'b0;
    logic       drawDone = 1'b0;
    logic [4:0] mazeAddrX, mazeAddrY;
    logic [4:0] xPlus, yPlus, xMinus, yMinus;
    logic       drawSpecial, busy, ready, fail;

    special_box_placer dut (
        .clk         (clk),
        .reset       (reset),
        .place       (place),
        .playerX     (playerX),
        .playerY     (playerY),
        .mazeWall    (mazeWall),
        .drawDone    (drawDone),
        .mazeAddrX   (mazeAddrX),
        .mazeAddrY   (mazeAddrY),
        .xPlus       (xPlus),
        .yPlus       (yPlus),
        .xMinus      (xMinus),
        .yMinus      (yMinus),
        .drawSpecial (drawSpecial),
        .busy        (busy),
        .ready       (ready),
        .fail        (fail)
    );

    typedef struct {
        int         mode;
        logic [4:0] px;
        logic [4:0] py;
        int         want;
        bit         spam;
    } vec_t;

    bit          wall_map [32][32];
    logic [15:0] m_lfsr;
    int          checks = 0;
    int          failures = 0;
    int          ready_cnt = 0;
    vec_t        vecs [7];

    always #5 clk = ~clk;

    always @(posedge clk) mazeWall <= wall_map[mazeAddrX][mazeAddrY];

    always @(posedge clk) if (ready) ready_cnt <= ready_cnt + 1;

    function automatic logic [15:0] step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= step(m_lfsr);
    end

    // stage: 0 plus-phase fail, 1 minus-phase fail, 2 placed
    function automatic void predict(
        input  logic [15:0] v0,
        output int          stage,
        output int          n,
        output logic [9:0]  pc,
        output logic [9:0]  mc
    );
        logic [15:0] v;
        logic [4:0]  x, y;
        int          att;
        bit          minus, bad;
        v = v0; att = 0; minus = 0;
        stage = -2; n = 0; pc = '0; mc = '0;
        for (int g = 0; g < 2000; g++) begin
            x = v[4:0];
            y = v[12:8];
            v = step(v);
            n++;
            bad = 1;
            if (x < 24 && y < 24) begin
                v = step(v);
                n++;
                bad = wall_map[x][y]
                   || (x == playerX && y == playerY)
                   || (minus && {x, y} == pc);
            end
            if (bad) begin
                att++;
                if (att == 64) begin
                    stage = minus ? 1 : 0;
                    return;
                end
            end else if (!minus) begin
                pc = {x, y};
                minus = 1;
                att = 0;
            end else begin
                mc = {x, y};
                stage = 2;
                return;
            end
        end
    endfunction

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_map(input int mode);
        for (int x = 0; x < 32; x++)
            for (int y = 0; y < 32; y++)
                case (mode)
                    0: wall_map[x][y] = 0;
                    1: wall_map[x][y] = 1;
                    2: wall_map[x][y] = !(x == 5 && y == 7);
                    default: wall_map[x][y] = $urandom_range(0, 99) < 30;
                endcase
    endtask

    function automatic logic [33:0] all_outs();
        return {mazeAddrX, mazeAddrY, xPlus, yPlus, xMinus, yMinus,
                drawSpecial, busy, ready, fail};
    endfunction

    task automatic run(input vec_t v);
        logic [19:0] pre, snap;
        logic [9:0]  pc, mc;
        int          stage, n, cnt, rc0;
        bit          found, stable, legal;
        set_map(v.mode);
        playerX = v.px;
        playerY = v.py;
        pre = {xPlus, yPlus, xMinus, yMinus};
        repeat ($urandom_range(0, 5)) tick();
        found = 0;
        for (int i = 0; i < 8000 && !found; i++) begin
            predict(step(m_lfsr), stage, n, pc, mc);
            if (v.want < 0 || stage == v.want) found = 1;
            else tick();
        end
        chk("search", 64'(found), 64'(1));
        if (!found) return;
        place = 1;
        rc0 = ready_cnt;
        tick();
        place = v.spam;
        cnt = 0;
        while (!drawSpecial && !fail && cnt < 1000) begin
            if (v.spam) drawDone = 1'($urandom_range(0, 1));
            tick();
            cnt++;
        end
        drawDone = 0;
        chk("latency", 64'(cnt), 64'(n));
        chk("outcome", 64'({drawSpecial, fail}),
            stage == 2 ? 64'd2 : 64'd1);
        if (stage == 2 && drawSpecial) begin
            chk("plus", 64'({xPlus, yPlus}), 64'(pc));
            chk("minus", 64'({xMinus, yMinus}), 64'(mc));
            legal = xPlus < 24 && yPlus < 24
                 && xMinus < 24 && yMinus < 24
                 && {xPlus, yPlus} != {xMinus, yMinus}
                 && {xPlus, yPlus} != {v.px, v.py}
                 && {xMinus, yMinus} != {v.px, v.py}
                 && !wall_map[xPlus][yPlus]
                 && !wall_map[xMinus][yMinus];
            chk("legal", 64'(legal), 64'(1));
            chk("busy_draw", 64'(busy), 64'(1));
            snap = {xPlus, yPlus, xMinus, yMinus};
            stable = 1;
            repeat ($urandom_range(2, 6)) begin
                tick();
                if ({xPlus, yPlus, xMinus, yMinus} != snap
                    || !drawSpecial || !busy) stable = 0;
            end
            chk("hold", 64'(stable), 64'(1));
            drawDone = 1;
            tick();
            drawDone = 0;
            place = 0;
            chk("rel_draw", 64'(drawSpecial), 64'(0));
            chk("rel_ready", 64'(ready), 64'(1));
            tick();
            chk("idle_busy", 64'({busy, ready}), 64'(0));
            chk("ready_once", 64'(ready_cnt - rc0), 64'(1));
            chk("kept", 64'({xPlus, yPlus, xMinus, yMinus}),
                64'(snap));
        end else if (stage < 2 && fail) begin
            place = 0;
            chk("fail_busy", 64'({busy, drawSpecial}), 64'(0));
            chk("fail_keep",
                64'({xPlus, yPlus, xMinus, yMinus}), 64'(pre));
            tick();
            chk("fail_pulse", 64'(fail), 64'(0));
            chk("fail_noready", 64'(ready_cnt - rc0), 64'(0));
        end
        place = 0;
        tick();
    endtask

    initial begin
        int cnt;
        vecs[0] = '{0, 5'd0, 5'd0, 2, 1'b0};
        vecs[1] = '{0, 5'd3, 5'd4, 2, 1'b0};
        vecs[2] = '{1, 5'd0, 5'd0, 0, 1'b0};
        vecs[3] = '{2, 5'd0, 5'd0, 1, 1'b0};
        vecs[4] = '{3, 5'($urandom_range(0, 23)),
                    5'($urandom_range(0, 23)), -1, 1'b0};
        vecs[5] = '{0, 5'd10, 5'd10, 2, 1'b1};
        vecs[6] = '{3, 5'($urandom_range(0, 23)),
                    5'($urandom_range(0, 23)), -1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", 64'(all_outs()), 64'(0));
        reset = 0;
        chk("rst_seed", 64'(dut.u_lfsr.q), 64'h0000_ACE1);
        tick();

        for (int i = 0; i < 7; i++) run(vecs[i]);

        set_map(0);
        playerX = 0;
        playerY = 0;
        place = 1;
        tick();
        place = 0;
        cnt = 0;
        while (!drawSpecial && cnt < 1000) begin
            tick();
            cnt++;
        end
        chk("pre_rst_draw", 64'(drawSpecial), 64'(1));
        #2;
        reset = 1;
        #1;
        chk("rst_async", 64'(all_outs()), 64'(0));
        @(posedge clk);
        #1;
        reset = 0;
        chk("rst_seed2", 64'(dut.u_lfsr.q), 64'h0000_ACE1);
        tick();

        run(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
